clock_multiphase: RTL and testbench



---
 rtl/time_package.sv | 38 +++
 rtl/clock_update_calc.sv | 45 ++++
 rtl/clock_multiphase.sv | 133 +++++++++++++
 tb/tb_clock_multiphase.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_package.sv
// rtl/time_package.sv - emulation time format and shared clock-generator types
package time_package;

    localparam int TIME_WIDTH = 40;
    localparam int TIME_POINT = 0;

    typedef logic [TIME_WIDTH-1:0] TIME_FORMAT;

    typedef enum logic {
        CLK_STOPPED,
        CLK_RUNNING
    } clk_state_t;

    // Right-shift Galois feedback masks giving maximal-length sequences
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = (32'h1 << (width - 1)) | (32'h1 << (width - 2));
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/clock_update_calc.sv
// rtl/clock_update_calc.sv - jittered, clamped time increment for the next clock edge
module clock_update_calc
    import time_package::*;
#(
    parameter int PERIOD_WIDTH       = 16,
    parameter int UPDATE_WIDTH       = 17,
    parameter int JITTER_WIDTH       = 12,
    parameter int JITTER_LFSR_WIDTH  = 8,
    parameter int JITTER_SCALE_WIDTH = 8,
    parameter int JITTER_SCALE_POINT = 8,
    parameter int MIN_UPDATE         = 1
) (
    input  logic [PERIOD_WIDTH-1:0]       period,
    input  logic [JITTER_LFSR_WIDTH-1:0]  lfsr,
    input  logic [JITTER_SCALE_WIDTH-1:0] jitter_scale,
    output logic [UPDATE_WIDTH-1:0]       upd
);

    localparam int PROD_WIDTH = JITTER_LFSR_WIDTH + JITTER_SCALE_WIDTH + 1 + JITTER_WIDTH;
    localparam int SHIFT      = JITTER_SCALE_POINT - TIME_POINT;
    localparam int SUM_WIDTH  = UPDATE_WIDTH + 1;

    localparam logic signed [SUM_WIDTH-1:0] MIN_SUM = SUM_WIDTH'(MIN_UPDATE);
    localparam logic signed [SUM_WIDTH-1:0] MAX_SUM = {1'b0, {UPDATE_WIDTH{1'b1}}};

    logic signed [PROD_WIDTH-1:0]   prod;
    logic signed [JITTER_WIDTH-1:0] jitter;
    logic signed [SUM_WIDTH-1:0]    sum;

    always_comb begin
        // Operands are widened before multiplying so the low bits equal the signed product
        prod   = {{(PROD_WIDTH - JITTER_LFSR_WIDTH){lfsr[JITTER_LFSR_WIDTH-1]}}, lfsr}
               * {{(PROD_WIDTH - JITTER_SCALE_WIDTH){1'b0}}, jitter_scale};
        jitter = JITTER_WIDTH'(prod >>> SHIFT);
        sum    = SUM_WIDTH'(signed'({1'b0, period})) + SUM_WIDTH'(jitter);

        upd = sum[UPDATE_WIDTH-1:0];
        if (sum < MIN_SUM) begin
            upd = UPDATE_WIDTH'(MIN_UPDATE);
        end else if (sum > MAX_SUM) begin
            upd = {UPDATE_WIDTH{1'b1}};
        end
    end

endmodule

// File: rtl/clock_multiphase.sv
// rtl/clock_multiphase.sv - emulated multiphase clock with jitter, run/stop and period shadow
module clock_multiphase
    import time_package::*;
#(
    parameter int N                  = 2,
    parameter int PERIOD_WIDTH       = 16,
    parameter int UPDATE_WIDTH       = 17,
    parameter int JITTER_WIDTH       = 12,
    parameter int JITTER_LFSR_WIDTH  = 8,
    parameter int JITTER_SCALE_WIDTH = 8,
    parameter int JITTER_SCALE_POINT = 8,
    parameter int LFSR_INIT          = 1,
    parameter int PERIOD_INIT        = 1000,
    parameter int MIN_UPDATE         = 1,
    parameter int EDGE_COUNT_WIDTH   = 32,
    localparam int PHASE_WIDTH       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TIME_WIDTH-1:0]         time_next,
    input  logic                          en,
    input  logic [PERIOD_WIDTH-1:0]       period_in,
    input  logic                          period_valid,
    output logic                          period_ready,
    input  logic [JITTER_SCALE_WIDTH-1:0] jitter_scale,
    output logic [TIME_WIDTH-1:0]         time_clock,
    output logic                          active,
    output logic                          time_eq,
    output logic [N-1:0]                  cke_out,
    output logic [PHASE_WIDTH-1:0]        phase,
    output logic [EDGE_COUNT_WIDTH-1:0]   edge_count
);

    localparam logic [JITTER_LFSR_WIDTH-1:0] LFSR_TAPS = JITTER_LFSR_WIDTH'(lfsr_taps(JITTER_LFSR_WIDTH));

    clk_state_t                   state;
    clk_state_t                   state_next;
    logic [JITTER_LFSR_WIDTH-1:0] lfsr;
    logic [JITTER_LFSR_WIDTH-1:0] lfsr_next;
    logic [PERIOD_WIDTH-1:0]      period;
    logic [PERIOD_WIDTH-1:0]      shadow;
    logic                         pending;
    logic [UPDATE_WIDTH-1:0]      upd;
    logic                         start;
    logic                         accept;
    logic                         apply;
    logic [N-1:0]                 phase_onehot;

    clock_update_calc #(
        .PERIOD_WIDTH      (PERIOD_WIDTH),
        .UPDATE_WIDTH      (UPDATE_WIDTH),
        .JITTER_WIDTH      (JITTER_WIDTH),
        .JITTER_LFSR_WIDTH (JITTER_LFSR_WIDTH),
        .JITTER_SCALE_WIDTH(JITTER_SCALE_WIDTH),
        .JITTER_SCALE_POINT(JITTER_SCALE_POINT),
        .MIN_UPDATE        (MIN_UPDATE)
    ) u_update_calc (
        .period      (period),
        .lfsr        (lfsr),
        .jitter_scale(jitter_scale),
        .upd         (upd)
    );

    assign active       = (state == CLK_RUNNING);
    assign time_eq      = active && (time_next == time_clock);
    assign start        = (state == CLK_STOPPED) && en;
    assign period_ready = ~pending;
    assign accept       = period_valid && !pending;
    // A start with a pending shadow defers the apply to the first edge
    assign apply        = pending && (time_eq || ((state == CLK_STOPPED) && !en));
    assign lfsr_next    = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

    always_comb begin
        state_next = state;
        case (state)
            CLK_STOPPED: if (en) state_next = CLK_RUNNING;
            CLK_RUNNING: if (time_eq && !en) state_next = CLK_STOPPED;
            default:     state_next = CLK_STOPPED;
        endcase
    end

    always_comb begin
        phase_onehot = '0;
        for (int i = 0; i < N; i++) begin
            phase_onehot[i] = (phase == PHASE_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLK_STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_clock <= '0;
            cke_out    <= '0;
            phase      <= '0;
            edge_count <= '0;
            lfsr       <= JITTER_LFSR_WIDTH'(LFSR_INIT);
            period     <= PERIOD_WIDTH'(PERIOD_INIT);
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            cke_out <= time_eq ? phase_onehot : '0;

            if (start) begin
                time_clock <= time_next + TIME_WIDTH'(upd);
                phase      <= '0;
            end else if (time_eq) begin
                // The stopping edge leaves time_clock at the time it fired
                if (en) begin
                    time_clock <= time_clock + TIME_WIDTH'(upd);
                end
                lfsr       <= lfsr_next;
                edge_count <= edge_count + EDGE_COUNT_WIDTH'(1);
                phase      <= (phase == PHASE_WIDTH'(N - 1)) ? '0 : phase + PHASE_WIDTH'(1);
            end

            if (accept) begin
                shadow  <= period_in;
                pending <= 1'b1;
            end else if (apply) begin
                period  <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_multiphase.sv
// tb/tb_clock_multiphase.sv - scoreboard bench for clock_multiphase
module tb_clock_multiphase;

    localparam int TW = time_package::TIME_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] time_next;
    logic          en;
    logic [15:0]   period_in;
    logic          period_valid;
    logic          period_ready;
    logic [7:0]    jitter_scale;
    logic [TW-1:0] time_clock;
    logic          active;
    logic          time_eq;
    logic [2:0]    cke_out;
    logic [1:0]    phase;
    logic [31:0]   edge_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    cke;
        logic [31:0]   ec;
        logic [TW-1:0] tc;
        logic [1:0]    ph;
    } exp_t;

    exp_t sb[$];

    logic [TW-1:0] m_tc;
    logic [7:0]    m_lfsr;
    int            m_period;
    logic [1:0]    m_phase;
    logic [31:0]   m_ec;

    clock_multiphase #(
        .N          (3),
        .PERIOD_INIT(10),
        .MIN_UPDATE (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .time_next   (time_next),
        .en          (en),
        .period_in   (period_in),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .jitter_scale(jitter_scale),
        .time_clock  (time_clock),
        .active      (active),
        .time_eq     (time_eq),
        .cke_out     (cke_out),
        .phase       (phase),
        .edge_count  (edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] ec, input logic [TW-1:0] tc,
                        input logic [1:0] ph);
        exp_t e;
        e.cke = c;
        e.ec  = ec;
        e.tc  = tc;
        e.ph  = ph;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [TW-1:0] tn);
        time_next = tn;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_time_clock"}, time_clock, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_cke_out"}, cke_out, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_edge_count"}, edge_count, 0);
        check({tag, "_period_ready"}, period_ready, 1);
        check({tag, "_time_eq"}, time_eq, 0);
    endtask

    function automatic int model_upd(input int per, input logic [7:0] l, input int scale);
        int j;
        int s;
        j = $signed(l) * scale;
        j = j >>> 8;
        s = per + j;
        if (s < 1) s = 1;
        if (s > 131071) s = 131071;
        return s;
    endfunction

    function automatic logic [7:0] model_lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic run_model(input int per, input int n);
        logic [TW-1:0] prev;
        logic [TW-1:0] fire_t;
        int            u;
        m_period = per;
        m_lfsr   = 8'h01;
        m_phase  = 2'd0;
        m_ec     = 32'd0;
        en       = 1'b1;
        m_tc     = 1000 + TW'(model_upd(per, m_lfsr, 255));
        cyc(1000);
        check("model_start_tc", time_clock, m_tc);
        for (int i = 0; i < n; i++) begin
            prev   = time_clock;
            u      = model_upd(m_period, m_lfsr, 255);
            fire_t = m_tc;
            push(3'b001 << m_phase, m_ec + 1, m_tc + TW'(u), (m_phase == 2'd2) ? 2'd0 : m_phase + 2'd1);
            m_lfsr  = model_lfsr_step(m_lfsr);
            m_ec    = m_ec + 1;
            m_phase = (m_phase == 2'd2) ? 2'd0 : m_phase + 2'd1;
            m_tc    = m_tc + TW'(u);
            cyc(fire_t);
            check("tc_increase", (time_clock > prev) && ((time_clock - prev) <= 131071), 1);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && cke_out != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_cke", cke_out, 0);
            end else begin
                e = sb.pop_front();
                check("cke_out", cke_out, e.cke);
                check("edge_count", edge_count, e.ec);
                check("time_clock", time_clock, e.tc);
                check("phase", phase, e.ph);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        time_next    = '0;
        period_in    = '0;
        period_valid = 1'b0;
        jitter_scale = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        cyc(0);

        // Basic rotation, scale 0, period 10
        en = 1'b1;
        cyc(100);
        check("start_tc", time_clock, 110);
        check("start_active", active, 1);
        check("start_phase", phase, 0);
        push(3'b001, 1, 120, 1); cyc(110);
        push(3'b010, 2, 130, 2); cyc(120);
        push(3'b100, 3, 140, 0); cyc(130);
        push(3'b001, 4, 150, 1); cyc(140);

        // Period change between edges
        time_next    = 145;
        period_in    = 25;
        period_valid = 1'b1;
        #1;
        check("between_edges_eq", time_eq, 0);
        @(posedge clk);
        #1;
        period_valid = 1'b0;
        time_next    = 150;
        #1;
        check("ready_pending", period_ready, 0);
        check("edge_eq", time_eq, 1);
        push(3'b010, 5, 160, 2);
        @(posedge clk);
        #1;
        check("ready_after_apply", period_ready, 1);
        push(3'b100, 6, 185, 0); cyc(160);

        // Accept coincident with an edge applies one edge later
        period_in    = 10;
        period_valid = 1'b1;
        push(3'b001, 7, 210, 1); cyc(185);
        period_valid = 1'b0;
        check("ready_coincident", period_ready, 0);
        push(3'b010, 8, 235, 2); cyc(210);
        push(3'b100, 9, 245, 0); cyc(235);
        check("ready_coincident_done", period_ready, 1);

        // Stop and restart
        en = 1'b0;
        cyc(240);
        check("still_active", active, 1);
        push(3'b001, 10, 245, 1); cyc(245);
        check("stopped_active", active, 0);
        check("stopped_tc_hold", time_clock, 245);
        time_next = 245;
        #1;
        check("stopped_eq_equal", time_eq, 0);
        cyc(245);
        time_next = 250;
        #1;
        check("stopped_eq_250", time_eq, 0);
        cyc(250);
        time_next = 260;
        #1;
        check("stopped_eq_260", time_eq, 0);
        cyc(260);
        en = 1'b1;
        cyc(300);
        check("restart_tc", time_clock, 310);
        check("restart_phase", phase, 0);
        check("restart_active", active, 1);
        push(3'b001, 11, 320, 1); cyc(310);
        cyc(315);

        // Clamp: period 2 with full jitter scale
        rst = 1'b1;
        en  = 1'b0;
        cyc(0);
        rst          = 1'b0;
        period_in    = 2;
        period_valid = 1'b1;
        jitter_scale = 8'hFF;
        cyc(0);
        period_valid = 1'b0;
        check("stopped_ready_low", period_ready, 0);
        cyc(0);
        check("stopped_ready_high", period_ready, 1);
        run_model(2, 256);

        // Reset mid-run with a pending shadow
        period_in    = 77;
        period_valid = 1'b1;
        cyc(m_tc - 1);
        period_valid = 1'b0;
        check("pending_before_reset", period_ready, 0);
        rst       = 1'b1;
        en        = 1'b0;
        time_next = m_tc;
        @(posedge clk);
        #1;
        reset_checks("midrun");
        rst = 1'b0;
        cyc(0);
        run_model(10, 16);

        en = 1'b0;
        cyc(0);
        cyc(0);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
